// File: rtl/imm_pack.sv
// LEGv8 immediate packer: encodes D/CB/B/I-type fields into a 32-bit word behind a 2-entry output FIFO.
// Define IMM_PACK_SAT_EN to saturate out-of-range immediates instead of truncating them.
module imm_pack (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_type,
  input  logic        in_load,
  input  logic [4:0]  in_rn,
  input  logic [4:0]  in_rt,
  input  logic [63:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] err_count
);

  typedef enum logic [1:0] {
    T_D  = 2'd0,
    T_CB = 2'd1,
    T_B  = 2'd2,
    T_I  = 2'd3
  } imm_type_e;

`ifdef IMM_PACK_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  logic [31:0] enc_instr;
  logic        enc_err;
  logic [8:0]  imm9;
  logic [18:0] imm19;
  logic [25:0] imm26;
  logic [11:0] imm12;

  // Range checks: a signed N-bit value fits when all bits above N-1 match the sign bit.
  always_comb begin
    enc_instr = '0;
    enc_err   = 1'b0;
    imm9      = in_imm[8:0];
    imm19     = in_imm[18:0];
    imm26     = in_imm[25:0];
    imm12     = in_imm[11:0];
    unique case (imm_type_e'(in_type))
      T_D: begin
        enc_err = !((&in_imm[63:8]) || !(|in_imm[63:8]));
        if (enc_err && SAT_EN) imm9 = in_imm[63] ? 9'h100 : 9'h0FF;
        enc_instr = {9'b111110000, in_load, 1'b0, imm9, 2'b00, in_rn, in_rt};
      end
      T_CB: begin
        enc_err = !((&in_imm[63:18]) || !(|in_imm[63:18]));
        if (enc_err && SAT_EN) imm19 = in_imm[63] ? 19'h40000 : 19'h3FFFF;
        enc_instr = {8'b10110100, imm19, in_rt};
      end
      T_B: begin
        enc_err = !((&in_imm[63:25]) || !(|in_imm[63:25]));
        if (enc_err && SAT_EN) imm26 = in_imm[63] ? 26'h2000000 : 26'h1FFFFFF;
        enc_instr = {6'b000101, imm26};
      end
      T_I: begin
        enc_err = |in_imm[63:12];
        if (enc_err && SAT_EN) imm12 = 12'hFFF;
        enc_instr = {10'b1001000100, imm12, in_rn, in_rt};
      end
      default: ;
    endcase
  end

  logic [32:0] mem_q [2];
  logic [32:0] mem_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        push, pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_instr = mem_q[rd_ptr_q][32:1];
  assign out_err   = mem_q[rd_ptr_q][0];
  assign err_count = err_cnt_q;

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q + {1'b0, push} - {1'b0, pop};
    err_cnt_d = err_cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = {enc_instr, enc_err};
      wr_ptr_d        = ~wr_ptr_q;
      if (enc_err && err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
  end

  // Storage is cleared too so out_instr/out_err read zero straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q     <= '{default: '0};
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_imm_pack.sv
// Self-checking bench for imm_pack: directed vector table, backpressure/reset sequences, random run vs. queue model.
module tb_imm_pack;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_type;
  logic        in_load;
  logic [4:0]  in_rn;
  logic [4:0]  in_rt;
  logic [63:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] err_count;

  int total = 0;
  int bad   = 0;
  int exp_ec = 0;

  always #5 clk = ~clk;

  imm_pack dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_load(in_load), .in_rn(in_rn), .in_rt(in_rt), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .err_count(err_count)
  );

  typedef struct {
    logic [1:0]  t;
    logic        ld;
    logic [4:0]  rn;
    logic [4:0]  rt;
    logic [63:0] imm;
    logic [31:0] exp_w;
    logic        exp_e;
  } vec_t;

  typedef struct {
    logic [31:0] w;
    logic        e;
  } word_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference encoder: legality by signed/unsigned integer compare, fields placed by multiplication.
  function automatic word_t ref_encode(input int t, input bit ld, input int rn, input int rt,
                                       input longint imm);
    longint lo, hi, v, f, w;
    int n;
    word_t r;
    case (t)
      0:       begin lo = -256;               hi = 255;                  n = 9;  end
      1:       begin lo = -(longint'(1) << 18); hi = (longint'(1) << 18) - 1; n = 19; end
      2:       begin lo = -(longint'(1) << 25); hi = (longint'(1) << 25) - 1; n = 26; end
      default: begin lo = 0;                  hi = 4095;                 n = 12; end
    endcase
    r.e = (imm < lo) || (imm > hi);
    v = imm;
`ifdef IMM_PACK_SAT_EN
    if (r.e) v = (imm < lo && t != 3) ? lo : hi;
`endif
    f = v & ((longint'(1) << n) - 1);
    case (t)
      0:       w = (ld ? 64'hF8400000 : 64'hF8000000) + f * 4096 + rn * 32 + rt;
      1:       w = 64'hB4000000 + f * 32 + rt;
      2:       w = 64'h14000000 + f;
      default: w = 64'h91000000 + f * 1024 + rn * 32 + rt;
    endcase
    r.w = w[31:0];
    return r;
  endfunction

  task automatic drive(input int t, input bit ld, input int rn, input int rt, input longint imm);
    in_type = 2'(t);
    in_load = ld;
    in_rn   = 5'(rn);
    in_rt   = 5'(rt);
    in_imm  = imm;
  endtask

  vec_t vecs[$];
  word_t q[$];
  word_t wa, wb, wc, wr;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(0, 0, 0, 0, 0);
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_err", out_err, 0);
    check("rst_err_count", err_count, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("rst_in_ready", in_ready, 1);

    // {type, load, rn, rt, imm, expected word, expected err}
    vecs.push_back('{2'd0, 1'b0, 5'd1, 5'd0, -64'sd256, 32'hF8100020, 1'b0});
    vecs.push_back('{2'd0, 1'b1, 5'd1, 5'd0, 64'd1,     32'hF8401020, 1'b0});
    vecs.push_back('{2'd1, 1'b0, 5'd0, 5'd0, 64'd1,     32'hB4000020, 1'b0});
    vecs.push_back('{2'd1, 1'b0, 5'd9, 5'd5, -64'sd262144, 32'hB4800005, 1'b0});
    vecs.push_back('{2'd2, 1'b0, 5'd7, 5'd7, -64'sd1,   32'h17FFFFFF, 1'b0});
    vecs.push_back('{2'd3, 1'b0, 5'd2, 5'd3, 64'd4095,  32'h913FFC43, 1'b0});
`ifdef IMM_PACK_SAT_EN
    vecs.push_back('{2'd0, 1'b0, 5'd1, 5'd0, 64'd256,   32'hF80FF020, 1'b1});
    vecs.push_back('{2'd1, 1'b0, 5'd0, 5'd0, 64'd262144, 32'hB47FFFE0, 1'b1});
    vecs.push_back('{2'd3, 1'b0, 5'd2, 5'd3, 64'd4096,  32'h913FFC43, 1'b1});
    vecs.push_back('{2'd2, 1'b0, 5'd0, 5'd0, -64'sd33554433, 32'h16000000, 1'b1});
`else
    vecs.push_back('{2'd0, 1'b0, 5'd1, 5'd0, 64'd256,   32'hF8100020, 1'b1});
    vecs.push_back('{2'd1, 1'b0, 5'd0, 5'd0, 64'd262144, 32'hB4800000, 1'b1});
    vecs.push_back('{2'd3, 1'b0, 5'd2, 5'd3, 64'd4096,  32'h91000043, 1'b1});
    vecs.push_back('{2'd2, 1'b0, 5'd0, 5'd0, -64'sd33554433, 32'h15FFFFFF, 1'b1});
`endif

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].t, vecs[i].ld, vecs[i].rn, vecs[i].rt, vecs[i].imm);
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      if (vecs[i].exp_e) exp_ec++;
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_instr", i), out_instr, vecs[i].exp_w);
      check($sformatf("vec%0d_err", i), out_err, vecs[i].exp_e);
      check($sformatf("vec%0d_errcnt", i), err_count, 64'(exp_ec));
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check($sformatf("vec%0d_drained", i), out_valid, 0);
    end

    // Backpressure: two accepts fill the FIFO, third waits; drain in order.
    wa = ref_encode(0, 1, 1, 0, 1);
    wb = ref_encode(0, 1, 1, 0, 2);
    wc = ref_encode(0, 1, 1, 0, 3);
    @(negedge clk);
    drive(0, 1, 1, 0, 1); in_valid = 1'b1;
    @(posedge clk); #1 drive(0, 1, 1, 0, 2);
    @(posedge clk); #1 drive(0, 1, 1, 0, 3);
    check("bp_full_in_ready", in_ready, 0);
    @(posedge clk); #1;
    check("bp_hold_in_ready", in_ready, 0);
    check("bp_hold_instr", out_instr, wa.w);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_pop1_instr", out_instr, wb.w);
    check("bp_pop1_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_pushpop_instr", out_instr, wc.w);
    check("bp_pushpop_valid", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_empty", out_valid, 0);

    // Reset with two buffered words, one erroneous.
    @(negedge clk);
    drive(0, 0, 1, 0, 256); in_valid = 1'b1;
    @(posedge clk); #1 drive(1, 0, 0, 0, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    check("pre_rst_errcnt", err_count, 64'(exp_ec + 1));
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_errcnt", err_count, 0);
    check("mid_rst_instr", out_instr, 0);
    exp_ec = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_valid", out_valid, 0);

    // Random traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      int t, rn, rt;
      bit ld, iv, ordy, push, pop;
      longint imm;
      @(negedge clk);
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) || err_count !== 16'(exp_ec)) begin
        check("rnd_out_valid", out_valid, q.size() > 0);
        check("rnd_in_ready", in_ready, q.size() < 2);
        check("rnd_err_count", err_count, 64'(exp_ec));
      end else total++;
      if (q.size() > 0) begin
        check("rnd_instr", out_instr, q[0].w);
        check("rnd_err", out_err, q[0].e);
      end
      t = $urandom_range(0, 3); ld = 1'($urandom); rn = $urandom_range(0, 31); rt = $urandom_range(0, 31);
      case ($urandom_range(0, 3))
        0: imm = longint'($urandom_range(0, 9000)) - 4500;
        1: imm = longint'($urandom_range(0, 8)) - 4 + (($urandom & 1) ? (longint'(1) << 18) : -(longint'(1) << 18));
        2: imm = longint'($urandom_range(0, 8)) - 4 + (($urandom & 1) ? (longint'(1) << 25) : -(longint'(1) << 25));
        default: imm = longint'({$urandom, $urandom});
      endcase
      iv = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      drive(t, ld, rn, rt, imm);
      in_valid = iv; out_ready = ordy;
      push = iv && (q.size() < 2);
      pop = ordy && (q.size() > 0);
      wr = ref_encode(t, ld, rn, rt, imm);
      @(posedge clk);
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(wr);
        if (wr.e && exp_ec < 65535) exp_ec++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("final_err_count", err_count, 64'(exp_ec));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
